reg_file_sb: RTL
================

# reg_file_sb

Parametrised register bank with a pending-write scoreboard. It replaces the combinational one-hot register bank with a clocked, binary-addressed array: one write port, two read ports with write-through bypass, and a per-register busy bit. The datapath control uses the busy bits to stall on operands still waiting for a long-latency result, such as a memory load. It sits between the decode stage (read ports, lock requests) and the writeback stage (write port).

## Interface
Parameters:
- WIDTH, 32, data width of each register
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- ZERO_R0, 0, when 1 register 0 reads as zero, ignores writes and ignores locks

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe (writeback)
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  WIDTH  read port A data (combinational)
- busy_a  out  1  register at rd_addr_a has a pending write
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  WIDTH  read port B data (combinational)
- busy_b  out  1  register at rd_addr_b has a pending write
- lock_en  in  1  mark lock_addr as pending (issue of a long-latency op)
- lock_addr  in  ADDR_W  register to lock
- lock_err  out  1  registered one-cycle pulse: lock_en hit an already-busy register
- busy_vec  out  DEPTH  all busy bits, bit i = register i

## Operation
- Storage: DEPTH x WIDTH flops (mem[i]) plus DEPTH busy flops (busy[i]).
- Write: on a rising clk edge with wr_en=1, mem[wr_addr] <= wr_data and busy[wr_addr] <= 0. The write is dropped when ZERO_R0=1 and wr_addr=0.
- Lock: on a rising clk edge with lock_en=1, busy[lock_addr] <= 1. The lock is ignored when ZERO_R0=1 and lock_addr=0.
- Lock and write to the same address in the same cycle: the data is written and busy ends at 1, because the lock is newer than the write.
- Lock and write to different addresses in the same cycle: both take effect.
- lock_err: next cycle it equals lock_en & busy[lock_addr] as sampled before the edge, unless the same-cycle write clears that address. The lock is still applied; busy stays 1.
- Read X in {a,b}:
  - Bypass: if wr_en=1 and wr_addr=rd_addr_X, rd_data_X=wr_data and busy_X=0.
  - Otherwise rd_data_X=mem[rd_addr_X] and busy_X=busy[rd_addr_X].
  - ZERO_R0=1 and rd_addr_X=0 forces rd_data_X=0 and busy_X=0, overriding the bypass.
- Both read ports are independent and may use the same address.
- busy_vec reflects the flop state with no bypass applied.

## Timing
- Reset (rst_n=0, asynchronous): all mem=0, all busy=0, lock_err=0. So busy_a=busy_b=0, busy_vec=0, and rd_data_X=0 unless a bypass is active. Release is synchronous to the next clk edge.
- Write latency:
  - Via the array: 1 cycle; data is visible from mem after the edge.
  - Via the bypass: 0 cycles, combinational in the same cycle.
- Lock latency: busy_X rises on the edge after lock_en.
- lock_err is a single-cycle pulse one edge after the offending lock; it is never sticky.
- Reset asserted mid-operation discards all pending locks and data immediately.
- No handshake on the write or lock ports. Every asserted strobe is accepted every cycle.

## Test plan
- Reset with WIDTH=32, ADDR_W=4: after rst_n deasserts, read all 16 addresses -> rd_data=0, busy_vec=16'h0000, lock_err=0.
- Write 32'hDEADBEEF to r5, next cycle read r5 on both ports -> 32'hDEADBEEF on each. In the write cycle with rd_addr_a=5 -> bypass gives 32'hDEADBEEF combinationally.
- Lock r3, then 2 cycles later write 32'h12345678 to r3:
  - Between the lock and the write: busy_a=1 for rd_addr_a=3, busy_vec=16'h0008.
  - In the write cycle: busy_a=0 and rd_data_a=32'h12345678 via the bypass.
  - After the write edge: busy_vec=0.
- Same-cycle lock_en and wr_en on r7 with data 32'hA5A5A5A5 -> next cycle mem[7]=32'hA5A5A5A5, busy[7]=1, lock_err=0.
- Lock r9 twice on consecutive cycles -> lock_err=1 for exactly one cycle, one edge after the second lock; busy[9] stays 1.
- ZERO_R0=1: write 32'hFFFFFFFF to r0 and lock r0 -> rd_data_a for address 0 is 0, busy_vec[0]=0, lock_err=0. Repeat with ZERO_R0=0 -> r0 holds 32'hFFFFFFFF and locks.
- Assert rst_n=0 mid-cycle while busy_vec=16'h0108 and r5 holds data -> busy_vec=0 and rd_data=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register bank with pending-write scoreboard: 1 write port, 2 bypassed read ports, per-register busy bit.
// Array writes and locks land on the next edge; reads and bypass are combinational; no backpressure.
module reg_file_sb #(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 4,
   parameter int ZERO_R0 = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [ADDR_W-1:0]        rd_addr_a,
   output logic [WIDTH-1:0]         rd_data_a,
   output logic                     busy_a,
   input  logic [ADDR_W-1:0]        rd_addr_b,
   output logic [WIDTH-1:0]         rd_data_b,
   output logic                     busy_b,
   input  logic                     lock_en,
   input  logic [ADDR_W-1:0]        lock_addr,
   output logic                     lock_err,
   output logic [(2**ADDR_W)-1:0]   busy_vec
);

   localparam int DEPTH = 2**ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic             wr_ok;
   logic             lock_ok;
   logic             lock_err_nxt;

   assign wr_ok   = wr_en   && !((ZERO_R0 != 0) && (wr_addr   == '0));
   assign lock_ok = lock_en && !((ZERO_R0 != 0) && (lock_addr == '0));

   // Lock is applied after the write so a same-address lock wins (it is the newer event).
   always_comb begin
      busy_nxt = busy;
      if (wr_ok)
         busy_nxt[wr_addr] = 1'b0;
      if (lock_ok)
         busy_nxt[lock_addr] = 1'b1;
   end

   assign lock_err_nxt = lock_ok && busy[lock_addr] && !(wr_ok && (wr_addr == lock_addr));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         busy     <= '0;
         lock_err <= 1'b0;
      end else begin
         if (wr_ok)
            mem[wr_addr] <= wr_data;
         busy     <= busy_nxt;
         lock_err <= lock_err_nxt;
      end
   end

   always_comb begin
      rd_data_a = mem[rd_addr_a];
      busy_a    = busy[rd_addr_a];
      if (wr_en && (wr_addr == rd_addr_a)) begin
         rd_data_a = wr_data;
         busy_a    = 1'b0;
      end
      if ((ZERO_R0 != 0) && (rd_addr_a == '0)) begin
         rd_data_a = '0;
         busy_a    = 1'b0;
      end
   end

   always_comb begin
      rd_data_b = mem[rd_addr_b];
      busy_b    = busy[rd_addr_b];
      if (wr_en && (wr_addr == rd_addr_b)) begin
         rd_data_b = wr_data;
         busy_b    = 1'b0;
      end
      if ((ZERO_R0 != 0) && (rd_addr_b == '0)) begin
         rd_data_b = '0;
         busy_b    = 1'b0;
      end
   end

   assign busy_vec = busy;

endmodule
